// File: rtl/mem_port_scheduler.sv
// Round-robin burst scheduler sharing one cellram between NUM_PORTS write and NUM_PORTS read FIFOs.
// Optional feature: define RD_PRIORITY_EN for low-water read-FIFO priority grants.
module mem_port_scheduler #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned REGION_W   = 20,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned MIN_BURST  = 2,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned LOW_WATER  = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_done_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]     wr_level_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]     rd_space_i,
  output logic                            req_valid_o,
  input  logic                            req_ready_i,
  output logic                            req_dir_o,
  output logic [$clog2(NUM_PORTS)-1:0]    req_port_o,
  output logic [ADDR_W-1:0]               req_len_o,
  input  logic                            done_i,
  input  logic [ADDR_W-1:0]               done_len_i,
  output logic [NUM_PORTS*(REGION_W+1)-1:0] ram_occ_o,
  output logic                            busy_o,
  output logic                            err_len_o
);

  localparam int unsigned PORT_W    = $clog2(NUM_PORTS);
  localparam int unsigned SLOT_W    = $clog2(2 * NUM_PORTS);
  localparam int unsigned OCC_W     = REGION_W + 1;
  localparam int unsigned LAST_SLOT = 2 * NUM_PORTS - 1;
  localparam logic [OCC_W-1:0] REGION_BYTES = {1'b1, {REGION_W{1'b0}}};
  localparam logic [OCC_W-1:0] EVEN_MASK    = ~(OCC_W'(1));
  localparam logic [OCC_W-1:0] MAX_LEN      = OCC_W'(MAX_BURST);

  // Reject configurations the length arithmetic cannot honour.
  if ((MIN_BURST < 2) || (MAX_BURST < MIN_BURST) || (LOW_WATER > FIFO_DEPTH)) begin : g_bad_cfg
    $error("mem_port_scheduler: inconsistent burst/water parameters");
  end

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic                   req_valid_q, req_valid_d;
  logic                   req_dir_q, req_dir_d;
  logic [PORT_W-1:0]      req_port_q, req_port_d;
  logic [ADDR_W-1:0]      req_len_q, req_len_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   prio_q, prio_d;
  logic [OCC_W-1:0]       occ_q [NUM_PORTS];
  logic [OCC_W-1:0]       occ_d [NUM_PORTS];

  logic [ADDR_W-1:0]      wr_lvl [NUM_PORTS];
  logic [ADDR_W-1:0]      rd_spc [NUM_PORTS];
  logic                   slot_dir;
  logic [PORT_W-1:0]      slot_port;
  logic [OCC_W-1:0]       scan_len;
  logic                   scan_ok;
  logic                   prio_hit;
  logic [PORT_W-1:0]      prio_port;
  logic [OCC_W-1:0]       prio_len;
  logic [ADDR_W-1:0]      moved_len;
  logic [SLOT_W-1:0]      served_slot;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ports
    assign wr_lvl[g] = wr_level_i[g*ADDR_W +: ADDR_W];
    assign rd_spc[g] = rd_space_i[g*ADDR_W +: ADDR_W];
    assign ram_occ_o[g*OCC_W +: OCC_W] = occ_q[g];
  end

  function automatic logic [OCC_W-1:0] min3(input logic [OCC_W-1:0] a,
                                            input logic [OCC_W-1:0] b,
                                            input logic [OCC_W-1:0] c);
    logic [OCC_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(LAST_SLOT)) ? '0 : s + 1'b1;
  endfunction

  // Burst size the slot under the pointer could take right now.
  always_comb begin
    slot_dir  = (slot_q >= SLOT_W'(NUM_PORTS));
    slot_port = PORT_W'(slot_dir ? slot_q - SLOT_W'(NUM_PORTS) : slot_q);
    if (slot_dir) begin
      scan_len = min3(occ_q[slot_port] & EVEN_MASK,
                      OCC_W'(rd_spc[slot_port]) & EVEN_MASK, MAX_LEN);
    end else begin
      scan_len = min3(OCC_W'(wr_lvl[slot_port]) & EVEN_MASK,
                      (REGION_BYTES - occ_q[slot_port]) & EVEN_MASK, MAX_LEN);
    end
    scan_ok = (scan_len >= OCC_W'(MIN_BURST));
  end

`ifdef RD_PRIORITY_EN
  // Lowest-numbered starving read FIFO with data in RAM; descending loop so the lowest wins.
  always_comb begin
    prio_hit  = 1'b0;
    prio_port = '0;
    prio_len  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((rd_spc[i] > ADDR_W'(FIFO_DEPTH - LOW_WATER)) &&
          (occ_q[i] >= OCC_W'(MIN_BURST))) begin
        prio_hit  = 1'b1;
        prio_port = PORT_W'(i);
        prio_len  = min3(occ_q[i] & EVEN_MASK, OCC_W'(rd_spc[i]) & EVEN_MASK, MAX_LEN);
      end
    end
  end
`else
  assign prio_hit  = 1'b0;
  assign prio_port = '0;
  assign prio_len  = '0;
`endif

  assign moved_len   = (done_len_i < req_len_q) ? done_len_i : req_len_q;
  assign served_slot = req_dir_q ? SLOT_W'(req_port_q) + SLOT_W'(NUM_PORTS)
                                 : SLOT_W'(req_port_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      req_valid_q <= 1'b0;
      req_dir_q   <= 1'b0;
      req_port_q  <= '0;
      req_len_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      prio_q      <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) occ_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      req_valid_q <= req_valid_d;
      req_dir_q   <= req_dir_d;
      req_port_q  <= req_port_d;
      req_len_q   <= req_len_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      prio_q      <= prio_d;
      occ_q       <= occ_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    req_valid_d = req_valid_q;
    req_dir_d   = req_dir_q;
    req_port_d  = req_port_q;
    req_len_d   = req_len_q;
    busy_d      = busy_q;
    err_d       = err_q;
    prio_d      = prio_q;
    occ_d       = occ_q;
    case (state_q)
      IDLE: if (cfg_done_i) state_d = SCAN;
      SCAN: begin
        if (!cfg_done_i) begin
          state_d = IDLE;
        end else if (prio_hit) begin
          state_d     = ISSUE;
          req_valid_d = 1'b1;
          busy_d      = 1'b1;
          req_dir_d   = 1'b1;
          req_port_d  = prio_port;
          req_len_d   = ADDR_W'(prio_len);
          prio_d      = 1'b1;
        end else if (scan_ok) begin
          state_d     = ISSUE;
          req_valid_d = 1'b1;
          busy_d      = 1'b1;
          req_dir_d   = slot_dir;
          req_port_d  = slot_port;
          req_len_d   = ADDR_W'(scan_len);
          prio_d      = 1'b0;
        end else begin
          slot_d = slot_inc(slot_q);
        end
      end
      ISSUE: begin
        if (req_ready_i) begin
          state_d     = BUSY;
          req_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (done_i) begin
          // Clamped length keeps occupancy within the region in both directions.
          if (req_dir_q) occ_d[req_port_q] = occ_q[req_port_q] - OCC_W'(moved_len);
          else           occ_d[req_port_q] = occ_q[req_port_q] + OCC_W'(moved_len);
          err_d   = err_q | (done_len_i > req_len_q);
          busy_d  = 1'b0;
          slot_d  = prio_q ? slot_q : slot_inc(served_slot);
          state_d = cfg_done_i ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_valid_o = req_valid_q;
  assign req_dir_o   = req_dir_q;
  assign req_port_o  = req_port_q;
  assign req_len_o   = req_len_q;
  assign busy_o      = busy_q;
  assign err_len_o   = err_q;

endmodule
